// File: rtl/pipe_stage_queue_pkg.sv
// Shared types and constants for the inter-stage pipeline queue.
// Holds the register-address type, the x0 constant and the default sizes.
// The helper below computes the destination register recorded for hazard tracking.
package pipe_stage_queue_pkg;

    localparam int PSQ_WIDTH_DEF = 256;
    localparam int PSQ_DEPTH_DEF = 2;
    localparam int PSQ_NQ_DEF    = 2;

    typedef logic [4:0] creg_addr_t;

    localparam creg_addr_t REG_X0 = 5'd0;

    // An entry that does not write a register is recorded with dst = x0.
    // x0 can never create a hazard, so such an entry needs no separate write flag.
    function automatic creg_addr_t pending_dst(input logic wen, input creg_addr_t dst);
        return wen ? dst : REG_X0;
    endfunction

endpackage

// File: rtl/pipe_hazard_cmp.sv
// Hazard comparator: compares one query register against every valid queue entry.
// Latency: combinational. Backpressure: none, this block is a pure function of its inputs.
// Ports: i_valid/i_dst give per-entry state, i_addr is the queried register, o_hit is the match flag.
module pipe_hazard_cmp
    import pipe_stage_queue_pkg::*;
#(
    parameter int DEPTH = PSQ_DEPTH_DEF
) (
    input  logic                   i_valid [DEPTH],
    input  creg_addr_t             i_dst   [DEPTH],
    input  creg_addr_t             i_addr,
    output logic                   o_hit
);

    always_comb begin
        o_hit = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            // A stored dst of x0 means "no write", so a query of x0 never hits.
            if (i_valid[e] && (i_dst[e] != REG_X0) && (i_dst[e] == i_addr)) begin
                o_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_queue.sv
// Circular FIFO between pipeline stages, with a synchronous flush and register-hazard query ports.
// Latency: 1 cycle, with no same-cycle bypass. Backpressure: o_in_ready = !full | i_out_ready, so a full queue accepts one entry in a cycle where it also dequeues one.
// Ports: i_in_* is the producer side, o_out_*/i_out_ready the consumer side, i_q_addr/o_q_hit the hazard queries, o_count the occupancy.
module pipe_stage_queue
    import pipe_stage_queue_pkg::*;
#(
    parameter int WIDTH = PSQ_WIDTH_DEF,
    parameter int DEPTH = PSQ_DEPTH_DEF,
    parameter int NQ    = PSQ_NQ_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_flush,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    input  logic [WIDTH-1:0]             i_in_data,
    input  logic                         i_in_wen,
    input  creg_addr_t                   i_in_dst,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic [WIDTH-1:0]             o_out_data,
    output creg_addr_t                   o_out_dst,
    input  logic [NQ*5-1:0]              i_q_addr,
    output logic [NQ-1:0]                o_q_hit,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    // DEPTH=1 would give zero-width pointers. A 1-bit pointer with a zero
    // increment keeps both pointers pinned at entry 0.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] qptr_t;
    typedef logic [CNT_W-1:0] qcnt_t;

    typedef struct packed {
        creg_addr_t         dst;
        logic [WIDTH-1:0]   data;
    } pipe_entry_t;

    localparam qptr_t PTR_ONE  = qptr_t'((DEPTH > 1) ? 1 : 0);
    localparam qcnt_t CNT_ONE  = qcnt_t'(1);
    localparam qcnt_t CNT_FULL = qcnt_t'(DEPTH);

    qptr_t        r_head;
    qptr_t        r_tail;
    qcnt_t        r_count;
    logic         r_valid [DEPTH];
    pipe_entry_t  r_mem   [DEPTH];

    logic         w_full;
    logic         w_enq;
    logic         w_deq;
    creg_addr_t   w_dst   [DEPTH];

    assign w_full      = (r_count == CNT_FULL);
    assign o_in_ready  = !w_full || i_out_ready;
    assign o_out_valid = (r_count != '0);
    assign o_count     = r_count;

    // Flush overrides both sides of the handshake. The input presented in a
    // flush cycle is dropped, and the head is not counted as consumed.
    assign w_enq = i_in_valid && o_in_ready && !i_flush;
    assign w_deq = o_out_valid && i_out_ready && !i_flush;

    // Force the outputs to zero when the queue is empty, so stale storage is never visible.
    assign o_out_data = o_out_valid ? r_mem[r_head].data : '0;
    assign o_out_dst  = o_out_valid ? r_mem[r_head].dst  : REG_X0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                r_valid[e] <= 1'b0;
            end
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                r_valid[e] <= 1'b0;
            end
        end else begin
            // When the queue is full and both enq and deq happen, head == tail.
            // The set is written after the clear, so the entry stays valid.
            if (w_deq) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_ONE;
            end
            if (w_enq) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PTR_ONE;
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_deq && !w_enq) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    // Payload storage has no reset; the valid bits alone qualify every entry.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_tail] <= '{dst: pending_dst(i_in_wen, i_in_dst), data: i_in_data};
        end
    end

    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            w_dst[e] = r_mem[e].dst;
        end
    end

    // Queries see only registered entries. An entry enqueued this cycle is not
    // yet visible; an entry dequeued this cycle is still visible.
    for (genvar q = 0; q < NQ; q++) begin : g_hazard
        pipe_hazard_cmp #(
            .DEPTH (DEPTH)
        ) u_hazard_cmp (
            .i_valid (r_valid),
            .i_dst   (w_dst),
            .i_addr  (i_q_addr[q*5 +: 5]),
            .o_hit   (o_q_hit[q])
        );
    end

endmodule
